wb_rr_shared_bus: RTL and testbench
===================================

Name: wb_rr_shared_bus

Overview:
- Parametrised Wishbone shared-bus interconnect for the SoC. It connects NM masters (CPU instruction/data ports, future DMA) to NS slaves (SDRAM, UART, GPIO, flash, new peripherals).
- It replaces fixed 8x8 wiring with sized arrays, fair round-robin arbitration, address decode, bus-error generation for unmapped addresses, and a per-transfer watchdog timeout.
- Only one master owns the bus at a time.

Parameters:
- NM, 2, number of masters (2..8)
- NS, 4, number of slaves (1..16)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- TIMEOUT, 255, cycles a strobed transfer may wait for ack/err before a bus error (1..65535)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- m_adr_i  in  NM*AW  master addresses; master k occupies slice [k*AW +: AW]
- m_dat_i  in  NM*DW  master write data
- m_sel_i  in  NM*DW/8  byte selects
- m_we_i  in  NM  write enables
- m_cyc_i  in  NM  cycle requests
- m_stb_i  in  NM  strobes
- m_dat_o  out  DW  read data, broadcast to all masters
- m_ack_o  out  NM  per-master ack
- m_err_o  out  NM  per-master bus error
- s_adr_o  out  AW  owner address, broadcast to slaves
- s_dat_o  out  DW  owner write data, broadcast
- s_sel_o  out  DW/8  owner byte selects, broadcast
- s_we_o  out  1  owner write enable, broadcast
- s_cyc_o  out  NS  per-slave cycle
- s_stb_o  out  NS  per-slave strobe
- s_dat_i  in  NS*DW  slave read data
- s_ack_i  in  NS  slave acks
- s_err_i  in  NS  slave errors
- gnt_o  out  3  index of current owner (valid while busy_o)
- busy_o  out  1  bus owned

Behaviour:
- Decode: slave index = adr[AW-1:AW-4] of the owner. Index >= NS is unmapped.
- FSM states are IDLE and OWN.
- IDLE:
  - If any m_cyc_i is high, pick the first requester scanning from (last+1) mod NM upward, wrapping.
  - Register gnt_o, set busy_o, update last, and go to OWN next cycle. Arbitration latency is 1 cycle.
  - With no requests, stay in IDLE.
- OWN:
  - Bus held while m_cyc_i[gnt] is high; other masters' requests are ignored (bus lock).
  - When m_cyc_i[gnt] falls, return to IDLE next cycle. Re-arbitration happens in IDLE, so there is a minimum 1 idle cycle between owners.
- Slave side (combinational, OWN only):
  - s_cyc_o[j] = m_cyc_i[gnt] & decode==j.
  - s_stb_o[j] = m_stb_i[gnt] & decode==j.
  - Broadcast s_adr_o, s_dat_o, s_sel_o and s_we_o from the owner. They are 0 in IDLE.
- Master side (combinational, OWN only):
  - m_dat_o = s_dat_i slice of the decoded slave, else 0.
  - m_ack_o[gnt] = s_ack_i[dec] & m_stb_i[gnt].
  - m_err_o[gnt] = s_err_i[dec] & m_stb_i[gnt], OR'd with the internal error pulse.
  - Non-owners always see ack/err = 0.
- Unmapped address:
  - No slave strobed.
  - Registered error pulse one cycle after stb is seen, exactly 1 cycle wide.
  - One pulse per strobed transfer; the next pulse needs stb low for one cycle or a fresh transfer.
- Timeout:
  - 16-bit counter runs while OWN & m_stb_i[gnt] & mapped & no ack/err.
  - Cleared on ack, err, stb low, or an ownership change.
  - When the count reaches TIMEOUT, pulse m_err_o[gnt] for 1 cycle; the counter clears.
  - If slave ack arrives in the same cycle the count hits TIMEOUT, ack wins and no error is generated.
  - If ack and err arrive from the slave together, both are passed through; err has no priority treatment.
- Reset (any cycle, including mid-transfer):
  - FSM goes to IDLE; busy_o=0, gnt_o=0.
  - last = NM-1, so master 0 has first priority.
  - Counter = 0; all s_cyc_o, s_stb_o, m_ack_o, m_err_o = 0.
  - Any in-flight transfer is abandoned.

Test Plan:
- Single read: m0 cyc/stb, adr 0x1000_0010 -> s_cyc_o=0b0010 next cycle; slave 1 acks with 0xDEADBEEF -> m_ack_o=0b01, m_dat_o=0xDEADBEEF same cycle.
- Round-robin: m0 and m1 both request continuously, each doing 1 transfer then dropping cyc for 1 cycle -> grants alternate 0,1,0,1; first grant after reset goes to master 0.
- Lock: m1 requests while m0 holds cyc over 3 back-to-back writes to slave 2 -> m1 gets no ack until m0 drops cyc; m1 is granted 1 cycle later.
- Unmapped: adr 0x5000_0000 with NS=4 -> all s_stb_o=0; m_err_o[gnt] is a 1-cycle pulse the cycle after stb.
- Timeout: TIMEOUT=8, slave 0 never acks -> m_err_o pulses after exactly 8 strobed cycles. Repeat with ack landing on cycle 8 -> ack only, no err.
- Reset mid-transfer: assert rst_i while m1 owns with stb high -> next cycle busy_o=0 and all strobes, acks and errs are 0; the following arbitration grants master 0.

Source files
------------

// File: rtl/wb_rr_shared_bus_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rr_shared_bus_if
//  Purpose  : Bundled master-side and slave-side Wishbone signals of the
//             shared-bus interconnect.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_rr_shared_bus_if #(
    parameter int NM = 2,
    parameter int NS = 4,
    parameter int AW = 32,
    parameter int DW = 32
);
    // Requests from the bus masters
    logic [NM*AW-1:0]     m_adr_i;
    logic [NM*DW-1:0]     m_dat_i;
    logic [NM*(DW/8)-1:0] m_sel_i;
    logic [NM-1:0]        m_we_i;
    logic [NM-1:0]        m_cyc_i;
    logic [NM-1:0]        m_stb_i;
    logic [DW-1:0]        m_dat_o;
    logic [NM-1:0]        m_ack_o;
    logic [NM-1:0]        m_err_o;

    // Owner's transfer as seen by the slaves
    logic [AW-1:0]        s_adr_o;
    logic [DW-1:0]        s_dat_o;
    logic [DW/8-1:0]      s_sel_o;
    logic                 s_we_o;
    logic [NS-1:0]        s_cyc_o;
    logic [NS-1:0]        s_stb_o;
    logic [NS*DW-1:0]     s_dat_i;
    logic [NS-1:0]        s_ack_i;
    logic [NS-1:0]        s_err_i;

    // Interconnect view: it drives the shared bus and answers the masters.
    modport master (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );

    // Endpoint view: masters and slaves attached around the interconnect.
    modport slave (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_rr_shared_bus.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rr_shared_bus
//  Purpose  : Round-robin Wishbone shared bus, NM masters to NS slaves, with
//             address decode, unmapped-address error and transfer watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module wb_rr_shared_bus #(
    parameter int NM      = 2,
    parameter int NS      = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    wb_rr_shared_bus_if.master bus,
    output logic [2:0]         gnt_o,
    output logic               busy_o
);
    localparam int          c_SW       = DW / 8;
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [2:0]  gnt_q;
    logic [2:0]  last_q;
    logic        busy_q;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        uerr_q, uerr_d;
    logic        uerr_done_q, uerr_done_d;
    logic        terr_q, terr_d;

    logic            w_own;
    logic [AW-1:0]   w_own_adr;
    logic [DW-1:0]   w_own_dat;
    logic [c_SW-1:0] w_own_sel;
    logic            w_own_we;
    logic            w_own_cyc;
    logic            w_own_stb;
    logic [3:0]      w_dec;
    logic            w_mapped;
    logic            w_s_ack;
    logic            w_s_err;
    logic            w_ack_own;
    logic            w_err_own;
    logic            w_unmap_fire;
    logic            w_tmo_run;
    logic            w_tmo_hit;
    logic            w_pick_vld;
    logic [2:0]      w_pick_idx;

    assign w_own = (state_q == ST_OWN);

    always_comb begin
        w_own_adr = '0;
        w_own_dat = '0;
        w_own_sel = '0;
        w_own_we  = 1'b0;
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (gnt_q == 3'(k)) begin
                w_own_adr = bus.m_adr_i[k*AW +: AW];
                w_own_dat = bus.m_dat_i[k*DW +: DW];
                w_own_sel = bus.m_sel_i[k*c_SW +: c_SW];
                w_own_we  = bus.m_we_i[k];
                w_own_cyc = bus.m_cyc_i[k];
                w_own_stb = bus.m_stb_i[k];
            end
        end
    end

    assign w_dec    = w_own_adr[AW-1 -: 4];
    assign w_mapped = ({1'b0, w_dec} < 5'(NS));

    // Rotating priority: first requester after the previous owner wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int i = 1; i <= NM; i++) begin
            if (!w_pick_vld && bus.m_cyc_i[(int'(last_q) + i) % NM]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = 3'((int'(last_q) + i) % NM);
            end
        end
    end

    always_comb begin
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_we_o  = 1'b0;
        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        bus.m_dat_o = '0;
        w_s_ack     = 1'b0;
        w_s_err     = 1'b0;
        if (w_own) begin
            bus.s_adr_o = w_own_adr;
            bus.s_dat_o = w_own_dat;
            bus.s_sel_o = w_own_sel;
            bus.s_we_o  = w_own_we;
            for (int j = 0; j < NS; j++) begin
                if (w_dec == 4'(j)) begin
                    bus.s_cyc_o[j] = w_own_cyc;
                    bus.s_stb_o[j] = w_own_stb;
                    bus.m_dat_o    = bus.s_dat_i[j*DW +: DW];
                    w_s_ack        = bus.s_ack_i[j];
                    w_s_err        = bus.s_err_i[j];
                end
            end
        end
    end

    assign w_ack_own = w_s_ack & w_own_stb;
    assign w_err_own = (w_s_err & w_own_stb) | uerr_q | terr_q;

    always_comb begin
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        if (w_own) begin
            for (int k = 0; k < NM; k++) begin
                if (gnt_q == 3'(k)) begin
                    bus.m_ack_o[k] = w_ack_own;
                    bus.m_err_o[k] = w_err_own;
                end
            end
        end
    end

    // One unmapped error per strobe run; re-armed by stb low or a new owner.
    assign w_unmap_fire = w_own & w_own_stb & ~w_mapped & ~uerr_done_q;
    assign uerr_d       = w_unmap_fire;
    assign uerr_done_d  = w_own & w_own_stb & ~w_mapped & (uerr_done_q | w_unmap_fire);

    assign w_tmo_run = w_own & w_own_stb & w_mapped & ~w_s_ack & ~w_s_err
                     & ~uerr_q & ~terr_q;
    assign w_tmo_hit = w_tmo_run && (tmo_cnt_q == c_TMO_LAST);
    assign tmo_cnt_d = (w_tmo_run && !w_tmo_hit) ? tmo_cnt_q + 16'd1 : 16'd0;
    assign terr_d    = w_tmo_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= 3'(NM - 1);
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        gnt_q   <= w_pick_idx;
                        last_q  <= w_pick_idx;
                        busy_q  <= 1'b1;
                        state_q <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!w_own_cyc) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q   <= '0;
            uerr_q      <= 1'b0;
            uerr_done_q <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            uerr_q      <= uerr_d;
            uerr_done_q <= uerr_done_d;
            terr_q      <= terr_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_shared_bus.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_rr_shared_bus
//  Purpose  : Directed and random checks of wb_rr_shared_bus against a
//             cycle-level behavioural model of the arbitration rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_rr_shared_bus;
    localparam int NM = 2, NS = 4, AW = 32, DW = 32, TIMEOUT = 8, SW = DW / 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] gnt;
    logic       busy;

    wb_rr_shared_bus_if #(.NM(NM), .NS(NS), .AW(AW), .DW(DW)) bus ();

    wb_rr_shared_bus #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .gnt_o  (gnt),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: who owns the bus, who was granted last, how long the owner waited.
    int owner_m = -1;
    int last_m  = NM - 1;
    int waited  = 0;
    bit tmo_due = 1'b0;
    bit ue_due  = 1'b0;
    bit ue_spent = 1'b0;

    logic          exp_busy;
    logic [2:0]    exp_gnt;
    logic [NS-1:0] exp_scyc, exp_sstb;
    logic [AW-1:0] exp_sadr;
    logic [DW-1:0] exp_sdat, exp_mdat;
    logic [SW-1:0] exp_ssel;
    logic          exp_swe;
    logic [NM-1:0] exp_ack, exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int slave_of(input int m);
        return int'(bus.m_adr_i[m*AW + AW - 4 +: 4]);
    endfunction

    task automatic model_predict();
        int s;
        exp_busy = (owner_m >= 0);
        exp_gnt  = '0;
        exp_scyc = '0; exp_sstb = '0; exp_sadr = '0; exp_sdat = '0;
        exp_ssel = '0; exp_swe  = 1'b0; exp_mdat = '0; exp_ack = '0; exp_err = '0;
        if (owner_m >= 0) begin
            s        = slave_of(owner_m);
            exp_gnt  = 3'(owner_m);
            exp_sadr = bus.m_adr_i[owner_m*AW +: AW];
            exp_sdat = bus.m_dat_i[owner_m*DW +: DW];
            exp_ssel = bus.m_sel_i[owner_m*SW +: SW];
            exp_swe  = bus.m_we_i[owner_m];
            if (s < NS) begin
                exp_scyc[s]       = bus.m_cyc_i[owner_m];
                exp_sstb[s]       = bus.m_stb_i[owner_m];
                exp_mdat          = bus.s_dat_i[s*DW +: DW];
                exp_ack[owner_m]  = bus.m_stb_i[owner_m] & bus.s_ack_i[s];
                exp_err[owner_m]  = bus.m_stb_i[owner_m] & bus.s_err_i[s];
            end
            if (ue_due || tmo_due) exp_err[owner_m] = 1'b1;
        end
    endtask

    task automatic model_clock();
        int  s;
        bit  stb, answered;
        if (rst) begin
            owner_m = -1; last_m = NM - 1; waited = 0;
            tmo_due = 0; ue_due = 0; ue_spent = 0;
            return;
        end
        if (owner_m < 0) begin
            waited = 0; tmo_due = 0; ue_due = 0; ue_spent = 0;
            for (int i = 1; i <= NM; i++) begin
                if (bus.m_cyc_i[(last_m + i) % NM]) begin
                    owner_m = (last_m + i) % NM;
                    last_m  = owner_m;
                    break;
                end
            end
        end else if (!bus.m_cyc_i[owner_m]) begin
            owner_m = -1; waited = 0; tmo_due = 0; ue_due = 0; ue_spent = 0;
        end else begin
            s        = slave_of(owner_m);
            stb      = bus.m_stb_i[owner_m];
            answered = exp_ack[owner_m] | exp_err[owner_m];
            if (stb && s >= NS) begin
                ue_due   = !ue_spent;
                ue_spent = 1'b1;
            end else begin
                ue_due   = 1'b0;
                ue_spent = 1'b0;
            end
            if (stb && s < NS && !answered) begin
                waited++;
                tmo_due = (waited == TIMEOUT);
                if (tmo_due) waited = 0;
            end else begin
                waited  = 0;
                tmo_due = 1'b0;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_predict();
        chk("busy", 64'(busy), 64'(exp_busy));
        if (exp_busy) chk("gnt", 64'(gnt), 64'(exp_gnt));
        chk("s_cyc", 64'(bus.s_cyc_o), 64'(exp_scyc));
        chk("s_stb", 64'(bus.s_stb_o), 64'(exp_sstb));
        chk("s_adr", 64'(bus.s_adr_o), 64'(exp_sadr));
        chk("s_dat", 64'(bus.s_dat_o), 64'(exp_sdat));
        chk("s_sel", 64'(bus.s_sel_o), 64'(exp_ssel));
        chk("s_we",  64'(bus.s_we_o),  64'(exp_swe));
        chk("m_dat", 64'(bus.m_dat_o), 64'(exp_mdat));
        chk("m_ack", 64'(bus.m_ack_o), 64'(exp_ack));
        chk("m_err", 64'(bus.m_err_o), 64'(exp_err));
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
        bus.m_we_i  = '0; bus.m_cyc_i = '0; bus.m_stb_i = '0;
        bus.s_dat_i = '0; bus.s_ack_i = '0; bus.s_err_i = '0;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb,
                         input logic [AW-1:0] adr, input logic we);
        bus.m_cyc_i[k]           = cyc;
        bus.m_stb_i[k]           = stb;
        bus.m_we_i[k]            = we;
        bus.m_adr_i[k*AW +: AW]  = adr;
        bus.m_dat_i[k*DW +: DW]  = DW'($urandom);
        bus.m_sel_i[k*SW +: SW]  = '1;
    endtask

    task automatic set_s(input int j, input logic ack, input logic err, input logic [DW-1:0] dat);
        bus.s_ack_i[j]          = ack;
        bus.s_err_i[j]          = err;
        bus.s_dat_i[j*DW +: DW] = dat;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NM-1:0] want;
        int            ngr;
        int            acks0;
        bit            was_busy;

        // Reset state
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        model_clock();
        #1;
        settle();
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_stb", 64'(bus.s_stb_o), 64'h0);
        advance();
        rst = 1'b0;

        // Single read from slave 1
        set_m(0, 1'b1, 1'b1, 32'h1000_0010, 1'b0);
        cycle();
        settle();
        chk("rd_scyc", 64'(bus.s_cyc_o), 64'h2);
        chk("rd_gnt", 64'(gnt), 64'h0);
        advance();
        set_s(1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        settle();
        chk("rd_ack", 64'(bus.m_ack_o), 64'h1);
        chk("rd_dat", 64'(bus.m_dat_o), 64'hDEAD_BEEF);
        advance();
        set_m(0, 1'b0, 1'b0, 32'h0, 1'b0);
        set_s(1, 1'b0, 1'b0, 32'h0);
        cycle();
        cycle();

        // Round-robin between two continuous requesters
        do_reset();
        set_s(0, 1'b1, 1'b0, 32'h0000_5A5A);
        want = '1; ngr = 0; was_busy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < NM; k++)
                set_m(k, want[k], want[k], 32'h0000_0100 * k, 1'b0);
            settle();
            if (busy && !was_busy) begin
                chk("rr_gnt", 64'(gnt), 64'(ngr % 2));
                ngr++;
            end
            was_busy = busy;
            for (int k = 0; k < NM; k++) want[k] = !bus.m_ack_o[k];
            advance();
        end
        chk("rr_count", 64'(ngr), 64'd4);
        idle_inputs();
        cycle();
        cycle();

        // Bus lock: m0 holds cyc over three writes while m1 waits
        do_reset();
        set_s(2, 1'b1, 1'b0, 32'h2222_2222);
        set_s(3, 1'b1, 1'b0, 32'h3333_3333);
        acks0 = 0;
        for (int c = 0; c < 8; c++) begin
            set_m(0, acks0 < 3, acks0 < 3, 32'h2000_0000 + 32'(c * 4), 1'b1);
            set_m(1, 1'b1, 1'b1, 32'h3000_0000, 1'b1);
            settle();
            if (c >= 1 && c <= 5) chk("lock_m1_quiet", 64'(bus.m_ack_o[1]), 64'h0);
            if (c == 6) begin
                chk("lock_gnt", 64'(gnt), 64'h1);
                chk("lock_busy", 64'(busy), 64'h1);
                chk("lock_m1_ack", 64'(bus.m_ack_o), 64'h2);
            end
            if (bus.m_ack_o[0]) acks0++;
            advance();
        end
        chk("lock_m0_acks", 64'(acks0), 64'd3);
        idle_inputs();
        cycle();
        cycle();

        // Unmapped address: single one-cycle error pulse
        for (int c = 0; c < 5; c++) begin
            set_m(0, c < 4, c < 4, 32'h5000_0000, 1'b0);
            settle();
            if (c == 1) begin
                chk("um_stb", 64'(bus.s_stb_o), 64'h0);
                chk("um_err_early", 64'(bus.m_err_o), 64'h0);
            end
            if (c == 2) chk("um_err", 64'(bus.m_err_o), 64'h1);
            if (c == 3) chk("um_err_once", 64'(bus.m_err_o), 64'h0);
            advance();
        end
        cycle();

        // Watchdog: slave 0 never answers
        for (int c = 0; c < 11; c++) begin
            set_m(0, c < 10, c < 10, 32'h0000_0040, 1'b0);
            settle();
            if (c >= 1 && c <= 8) chk("tmo_quiet", 64'(bus.m_err_o), 64'h0);
            if (c == 9) chk("tmo_err", 64'(bus.m_err_o), 64'h1);
            advance();
        end
        cycle();

        // Watchdog: ack lands on the eighth strobed cycle
        for (int c = 0; c < 11; c++) begin
            set_m(0, c < 10, c < 10, 32'h0000_0040, 1'b0);
            set_s(0, c == 8, 1'b0, 32'h1234_5678);
            settle();
            if (c == 8) begin
                chk("tmo_ack", 64'(bus.m_ack_o), 64'h1);
                chk("tmo_ack_noerr", 64'(bus.m_err_o), 64'h0);
            end
            if (c == 9) chk("tmo_after_ack", 64'(bus.m_err_o), 64'h0);
            advance();
        end
        idle_inputs();
        cycle();

        // Reset while m1 owns with stb high
        set_m(1, 1'b1, 1'b1, 32'h1000_0000, 1'b0);
        cycle();
        settle();
        chk("mr_gnt", 64'(gnt), 64'h1);
        chk("mr_stb", 64'(bus.s_stb_o), 64'h2);
        advance();
        set_m(0, 1'b1, 1'b1, 32'h2000_0000, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int j = 0; j < NS; j++) set_s(j, 1'b1, 1'b1, DW'($urandom));
        settle();
        chk("mr_busy", 64'(busy), 64'h0);
        chk("mr_cyc", 64'(bus.s_cyc_o), 64'h0);
        chk("mr_ack", 64'(bus.m_ack_o), 64'h0);
        chk("mr_err", 64'(bus.m_err_o), 64'h0);
        advance();
        settle();
        chk("mr_regnt", 64'(gnt), 64'h0);
        chk("mr_both_ack", 64'(bus.m_ack_o), 64'h1);
        chk("mr_both_err", 64'(bus.m_err_o), 64'h1);
        advance();
        idle_inputs();
        cycle();
        cycle();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int k = 0; k < NM; k++) begin
                if ($urandom_range(0, 7) == 0) bus.m_cyc_i[k] = ~bus.m_cyc_i[k];
                bus.m_stb_i[k] = bus.m_cyc_i[k] & ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 5) == 0)
                    bus.m_adr_i[k*AW +: AW] = {4'($urandom_range(0, 5)), 28'($urandom)};
                bus.m_we_i[k]           = 1'($urandom);
                bus.m_dat_i[k*DW +: DW] = DW'($urandom);
                bus.m_sel_i[k*SW +: SW] = SW'($urandom);
            end
            for (int j = 0; j < NS; j++)
                set_s(j, $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0, DW'($urandom));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
